// File: rtl/ram_rw_pkg.sv
// Shared definitions for the UART RAM/CPU-control protocol: command codes,
// request opcodes and the loader's internal state encodings.
package ram_rw_pkg;

    localparam int XLEN = 32;

    typedef enum logic [7:0] {
        CMD_RST     = 8'h2a,
        CMD_RUN     = 8'h2b,
        CMD_CONF_WR = 8'h2c,
        CMD_CONF_RD = 8'h2d,
        CMD_DATA_WR = 8'h2e,
        CMD_DATA_RD = 8'h2f
    } cmd_en_t;

    typedef enum logic [1:0] {
        OP_RST  = 2'd0,
        OP_RUN  = 2'd1,
        OP_LOAD = 2'd2,
        OP_DUMP = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_SEND_CFG,
        ST_SEND_DCMD,
        ST_FETCH,
        ST_SEND_DATA,
        ST_RECV,
        ST_DONE
    } loader_state_e;

    typedef enum logic [1:0] {
        TX_LAUNCH,
        TX_ACK,
        TX_WAIT_IDLE
    } tx_phase_e;

    // RST and RUN are single-byte commands; LOAD and DUMP open with a config write.
    function automatic cmd_en_t op_cmd(input op_e op);
        case (op)
            OP_RST:  return CMD_RST;
            OP_RUN:  return CMD_RUN;
            default: return CMD_CONF_WR;
        endcase
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [XLEN-1:0] addr,
                                            input logic [XLEN-1:0] size,
                                            input logic [2:0]      idx);
        logic [2*XLEN-1:0] cfg;
        cfg = {size, addr};
        return cfg[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/edge2en.sv
// Rising-edge detector: rise_o is high for the single cycle in which in_i
// is high after having been low on the previous clock.
module edge2en (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic in_i,
    output logic rise_o
);

    logic in_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_i;
        end
    end

    assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/ram_loader.sv
// Host-side UART command initiator: turns RST/RUN/LOAD/DUMP requests into the
// responder's byte protocol, streaming load data in and dump data out.
module ram_loader
    import ram_rw_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_vld_i,
    input  logic [1:0]      req_op_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_size_i,
    output logic            req_rdy_o,
    output logic            done_o,
    output logic            src_rd_o,
    input  logic [7:0]      src_data_i,
    output logic [7:0]      snk_data_o,
    output logic            snk_vld_o,
    output logic [7:0]      uart_tx_data_o,
    output logic            uart_tx_data_vld_o,
    input  logic            uart_tx_data_rdy_i,
    input  logic [7:0]      uart_rx_data_i,
    input  logic            uart_rx_data_vld_i,
    output logic            uart_rx_data_rdy_o
);

    loader_state_e   state_q, state_d;
    tx_phase_e       phase_q;
    op_e             op_q;
    logic [XLEN-1:0] addr_q, size_q, cnt_q;
    logic [7:0]      load_q, tx_byte;
    logic            fetch_q, tx_rise, rx_rise, tx_done, cnt_last, sending, accept;

    edge2en u_tx_rdy_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .in_i    (uart_tx_data_rdy_i),
        .rise_o  (tx_rise)
    );

    edge2en u_rx_vld_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .in_i    (uart_rx_data_vld_i),
        .rise_o  (rx_rise)
    );

    assign req_rdy_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done_o    = (state_q == ST_DONE);
    assign src_rd_o  = (state_q == ST_FETCH);
    assign accept    = req_vld_i & req_rdy_o;
    assign cnt_last  = (cnt_q == size_q);
    assign sending   = state_q inside {ST_SEND_CMD, ST_SEND_CFG, ST_SEND_DCMD, ST_SEND_DATA};
    // A byte only counts as finished once the transmitter reports idle again.
    assign tx_done   = (phase_q == TX_WAIT_IDLE) && tx_rise;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (req_vld_i) state_d = ST_SEND_CMD;
            ST_SEND_CMD:  if (tx_done) state_d = (op_q == OP_RST || op_q == OP_RUN) ? ST_DONE : ST_SEND_CFG;
            ST_SEND_CFG:  if (tx_done && cnt_q[2:0] == 3'd7) state_d = ST_SEND_DCMD;
            ST_SEND_DCMD: if (tx_done) state_d = (op_q == OP_LOAD) ? ST_FETCH : ST_RECV;
            ST_FETCH:     state_d = ST_SEND_DATA;
            ST_SEND_DATA: if (tx_done) state_d = cnt_last ? ST_DONE : ST_FETCH;
            ST_RECV:      if (rx_rise && cnt_last) state_d = ST_DONE;
            ST_DONE:      state_d = req_vld_i ? ST_SEND_CMD : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // The fetched byte is only on src_data_i for one cycle, so it is also parked in load_q.
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            ST_SEND_CMD:  tx_byte = op_cmd(op_q);
            ST_SEND_CFG:  tx_byte = cfg_byte(addr_q, size_q, cnt_q[2:0]);
            ST_SEND_DCMD: tx_byte = (op_q == OP_LOAD) ? CMD_DATA_WR : CMD_DATA_RD;
            ST_SEND_DATA: tx_byte = fetch_q ? src_data_i : load_q;
            default:      tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q    <= OP_RST;
            addr_q  <= '0;
            size_q  <= '0;
            fetch_q <= 1'b0;
            load_q  <= 8'h00;
        end else begin
            fetch_q <= (state_q == ST_FETCH);
            if (fetch_q) begin
                load_q <= src_data_i;
            end
            if (accept) begin
                op_q   <= op_e'(req_op_i);
                addr_q <= req_addr_i;
                size_q <= req_size_i;
            end
        end
    end

    // Cleared when leaving the command states so it starts at zero in SEND_CFG, FETCH and RECV.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if ((state_q == ST_SEND_CMD || state_q == ST_SEND_DCMD) && tx_done) begin
            cnt_q <= '0;
        end else if (((state_q == ST_SEND_CFG || state_q == ST_SEND_DATA) && tx_done) ||
                     (state_q == ST_RECV && rx_rise)) begin
            cnt_q <= cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q            <= TX_LAUNCH;
            uart_tx_data_vld_o <= 1'b0;
            uart_tx_data_o     <= 8'h00;
        end else begin
            case (phase_q)
                TX_LAUNCH: begin
                    if (sending && uart_tx_data_rdy_i) begin
                        uart_tx_data_vld_o <= 1'b1;
                        uart_tx_data_o     <= tx_byte;
                        phase_q            <= TX_ACK;
                    end
                end
                TX_ACK: begin
                    if (!uart_tx_data_rdy_i) begin
                        uart_tx_data_vld_o <= 1'b0;
                        phase_q            <= TX_WAIT_IDLE;
                    end
                end
                TX_WAIT_IDLE: begin
                    if (tx_rise) begin
                        phase_q <= TX_LAUNCH;
                    end
                end
                default: phase_q <= TX_LAUNCH;
            endcase
        end
    end

    // Bytes arriving outside RECV are still acknowledged so the link never stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            uart_rx_data_rdy_o <= 1'b0;
            snk_vld_o          <= 1'b0;
            snk_data_o         <= 8'h00;
        end else begin
            if (rx_rise) begin
                uart_rx_data_rdy_o <= 1'b1;
            end else if (!uart_rx_data_vld_i) begin
                uart_rx_data_rdy_o <= 1'b0;
            end
            snk_vld_o <= rx_rise && (state_q == ST_RECV);
            if (rx_rise && state_q == ST_RECV) begin
                snk_data_o <= uart_rx_data_i;
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: UART TX/RX, byte source and sink are modelled
// behaviourally and every sent or received byte is compared with a hand-made table.
module tb_ram_loader;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_vld_i = 1'b0;
    logic [1:0]  req_op_i = 2'd0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_size_i = 32'd0;
    logic        req_rdy_o, done_o, src_rd_o, snk_vld_o;
    logic [7:0]  src_data_i = 8'h00;
    logic [7:0]  snk_data_o, uart_tx_data_o;
    logic        uart_tx_data_vld_o;
    logic        uart_tx_data_rdy_i = 1'b1;
    logic [7:0]  uart_rx_data_i = 8'h00;
    logic        uart_rx_data_vld_i = 1'b0;
    logic        uart_rx_data_rdy_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq[$];
    logic [7:0] snkq[$];
    logic [7:0] src_mem [64];
    logic [7:0] rx_src [32];
    int src_rd_cnt = 0;
    int done_cnt = 0;
    int rx_hs_cnt = 0;
    int tx_busy = 0;
    int tx_idle = 0;
    int rx_gap = 0;
    int rx_rd = 0;
    int rx_wr = 0;
    int rx_arm = 0;
    logic src_pend = 1'b0;

    logic [7:0] exp_load [14] = '{8'h2c, 8'h10, 8'h00, 8'h00, 8'h80, 8'h03, 8'h00, 8'h00,
                                  8'h00, 8'h2e, 8'ha0, 8'ha1, 8'ha2, 8'ha3};
    logic [7:0] exp_dump [10] = '{8'h2c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                                  8'h00, 8'h2f};
    logic [7:0] exp_lb_cfg [10] = '{8'h2c, 8'h00, 8'h01, 8'h00, 8'h00, 8'h0f, 8'h00, 8'h00,
                                    8'h00, 8'h2e};

    ram_loader dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .req_vld_i          (req_vld_i),
        .req_op_i           (req_op_i),
        .req_addr_i         (req_addr_i),
        .req_size_i         (req_size_i),
        .req_rdy_o          (req_rdy_o),
        .done_o             (done_o),
        .src_rd_o           (src_rd_o),
        .src_data_i         (src_data_i),
        .snk_data_o         (snk_data_o),
        .snk_vld_o          (snk_vld_o),
        .uart_tx_data_o     (uart_tx_data_o),
        .uart_tx_data_vld_o (uart_tx_data_vld_o),
        .uart_tx_data_rdy_i (uart_tx_data_rdy_i),
        .uart_rx_data_i     (uart_rx_data_i),
        .uart_rx_data_vld_i (uart_rx_data_vld_i),
        .uart_rx_data_rdy_o (uart_rx_data_rdy_o)
    );

    always #5 clk_i = ~clk_i;

    // UART transmitter: takes a byte when idle, then stays busy for ten cycles.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            uart_tx_data_rdy_i = 1'b1;
            tx_busy = 0;
            tx_idle = 0;
        end else if (uart_tx_data_rdy_i) begin
            tx_idle++;
            if (uart_tx_data_vld_o) begin
                txq.push_back(uart_tx_data_o);
                uart_tx_data_rdy_i = 1'b0;
                tx_busy = 10;
                tx_idle = 0;
            end
        end else if (tx_busy > 0) begin
            tx_busy--;
        end else begin
            uart_tx_data_rdy_i = 1'b1;
        end
    end

    // UART receiver: presents queued bytes once the armed number of bytes has gone out.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            uart_rx_data_vld_i = 1'b0;
            rx_gap = 0;
        end else if (uart_rx_data_vld_i) begin
            if (uart_rx_data_rdy_o) begin
                uart_rx_data_vld_i = 1'b0;
                rx_hs_cnt++;
                rx_gap = 4;
            end
        end else if (rx_gap > 0) begin
            rx_gap--;
        end else if (rx_rd < rx_wr && txq.size() >= rx_arm && tx_idle >= 3) begin
            uart_rx_data_i = rx_src[rx_rd];
            rx_rd++;
            uart_rx_data_vld_i = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (src_pend) begin
            src_data_i = src_mem[src_rd_cnt-1];
        end
        src_pend = src_rd_o;
        if (src_rd_o) begin
            src_rd_cnt++;
        end
        if (snk_vld_o) begin
            snkq.push_back(snk_data_o);
        end
        if (done_o) begin
            done_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] size);
        @(negedge clk_i);
        checkOutput("req_rdy_before_req", 32'(req_rdy_o), 32'd1);
        req_op_i   = op;
        req_addr_i = addr;
        req_size_i = size;
        req_vld_i  = 1'b1;
        @(negedge clk_i);
        req_vld_i  = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        bit rdy_early = 1'b0;
        while (!done_o && n < budget) begin
            if (req_rdy_o) rdy_early = 1'b1;
            @(negedge clk_i);
            n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(done_o), 32'd1);
        checkOutput({tag, "_rdy_low_while_busy"}, 32'(rdy_early), 32'd0);
        checkOutput({tag, "_rdy_with_done"}, 32'(req_rdy_o), 32'd1);
        @(negedge clk_i);
        checkOutput({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, base2, snk0, src0, hs0, seen, n;

        for (int i = 0; i < 64; i++) src_mem[i] = 8'(i * 7 + 3);
        src_mem[0] = 8'ha0;
        src_mem[1] = 8'ha1;
        src_mem[2] = 8'ha2;
        src_mem[3] = 8'ha3;

        repeat (3) @(negedge clk_i);
        checkOutput("reset_outputs",
                    {10'd0, req_rdy_o, done_o, src_rd_o, snk_vld_o, uart_tx_data_vld_o,
                     uart_rx_data_rdy_o, uart_tx_data_o, snk_data_o}, 32'h0020_0000);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        $display("[TB] RUN request");
        base = txq.size();
        applyStimulus(2'd1, 32'd0, 32'd0);
        checkOutput("run_rdy_low_after_accept", 32'(req_rdy_o), 32'd0);
        checkOutput("run_vld_not_yet", 32'(uart_tx_data_vld_o), 32'd0);
        @(negedge clk_i);
        checkOutput("run_vld_latency", 32'(uart_tx_data_vld_o), 32'd1);
        checkOutput("run_vld_data", 32'(uart_tx_data_o), 32'h2b);
        waitDone("run", 300);
        checkOutput("run_byte_count", 32'(txq.size() - base), 32'd1);
        checkOutput("run_byte", 32'(txq[base]), 32'h2b);

        $display("[TB] LOAD with ignored mid-transfer request");
        base = txq.size();
        src0 = src_rd_cnt;
        applyStimulus(2'd2, 32'h8000_0010, 32'd3);
        repeat (30) @(negedge clk_i);
        req_op_i  = 2'd0;
        req_vld_i = 1'b1;
        @(negedge clk_i);
        req_vld_i = 1'b0;
        waitDone("load", 3000);
        checkOutput("load_byte_count", 32'(txq.size() - base), 32'd14);
        for (int i = 0; i < 14; i++)
            checkOutput($sformatf("load_byte%0d", i), 32'(txq[base+i]), 32'(exp_load[i]));
        checkOutput("load_src_rd_pulses", 32'(src_rd_cnt - src0), 32'd4);
        repeat (40) @(negedge clk_i);
        checkOutput("load_no_extra_bytes", 32'(txq.size() - base), 32'd14);

        $display("[TB] unsolicited RX byte in idle");
        hs0  = rx_hs_cnt;
        snk0 = snkq.size();
        rx_src[0] = 8'h77;
        rx_arm = 0;
        rx_wr  = 1;
        repeat (20) @(negedge clk_i);
        checkOutput("idle_rx_handshaked", 32'(rx_hs_cnt - hs0), 32'd1);
        checkOutput("idle_rx_no_sink", 32'(snkq.size() - snk0), 32'd0);
        checkOutput("idle_rx_rdy_released", 32'(uart_rx_data_rdy_o), 32'd0);

        $display("[TB] DUMP two bytes");
        base = txq.size();
        snk0 = snkq.size();
        rx_src[1] = 8'h55;
        rx_src[2] = 8'haa;
        rx_arm = base + 10;
        rx_wr  = 3;
        applyStimulus(2'd3, 32'd0, 32'd1);
        waitDone("dump", 3000);
        checkOutput("dump_byte_count", 32'(txq.size() - base), 32'd10);
        for (int i = 0; i < 10; i++)
            checkOutput($sformatf("dump_byte%0d", i), 32'(txq[base+i]), 32'(exp_dump[i]));
        checkOutput("dump_sink_count", 32'(snkq.size() - snk0), 32'd2);
        checkOutput("dump_sink0", 32'(snkq[snk0]), 32'h55);
        checkOutput("dump_sink1", 32'(snkq[snk0+1]), 32'haa);

        $display("[TB] loopback LOAD/DUMP of 16 bytes");
        base = txq.size();
        applyStimulus(2'd2, 32'h0000_0100, 32'd15);
        waitDone("lb_load", 6000);
        checkOutput("lb_load_count", 32'(txq.size() - base), 32'd26);
        for (int i = 0; i < 10; i++)
            checkOutput($sformatf("lb_cfg%0d", i), 32'(txq[base+i]), 32'(exp_lb_cfg[i]));
        for (int i = 0; i < 16; i++)
            rx_src[3+i] = txq[base+10+i];
        base2 = txq.size();
        snk0  = snkq.size();
        rx_arm = base2 + 10;
        rx_wr  = 19;
        applyStimulus(2'd3, 32'h0000_0100, 32'd15);
        waitDone("lb_dump", 6000);
        checkOutput("lb_sink_count", 32'(snkq.size() - snk0), 32'd16);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("lb_data%0d", i), 32'(snkq[snk0+i]), 32'(src_mem[4+i]));

        $display("[TB] reset during SEND_DATA");
        applyStimulus(2'd2, 32'h0000_0040, 32'd7);
        seen = 0;
        n = 0;
        while (seen < 2 && n < 1000) begin
            @(negedge clk_i);
            if (src_rd_o) seen++;
            n++;
        end
        checkOutput("rst_reached_fetch", 32'(seen), 32'd2);
        repeat (2) @(negedge clk_i);
        checkOutput("rst_pre_vld", 32'(uart_tx_data_vld_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("rst_async_outputs",
                    {10'd0, req_rdy_o, done_o, src_rd_o, snk_vld_o, uart_tx_data_vld_o,
                     uart_rx_data_rdy_o, uart_tx_data_o, snk_data_o}, 32'h0020_0000);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        base = txq.size();
        applyStimulus(2'd0, 32'd0, 32'd0);
        waitDone("rst_cmd", 300);
        checkOutput("rst_cmd_count", 32'(txq.size() - base), 32'd1);
        checkOutput("rst_cmd_byte", 32'(txq[base]), 32'h2a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Host-side initiator for the UART RAM/CPU-control command protocol. It turns a local request (reset, run, load, dump) into the byte sequence the target-side command responder expects on its UART receive link. It streams load data from a local byte source and returns dump data to a local byte sink. It sits between a byte-level UART transceiver and a host controller, such as a test harness, a boot ROM sequencer or a debug bridge.

## Interface
- XLEN, 32: width of address, size and byte counter.
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- req_vld_i  in  1  request strobe; sampled only when req_rdy_o=1.
- req_op_i  in  2  0=RST, 1=RUN, 2=LOAD, 3=DUMP.
- req_addr_i  in  XLEN  target RAM start address.
- req_size_i  in  XLEN  transfer length minus one, in bytes.
- req_rdy_o  out  1  idle, accepting requests.
- done_o  out  1  one-cycle pulse when a request completes.
- src_rd_o  out  1  one-cycle fetch strobe for the next load byte.
- src_data_i  in  8  load byte, valid the cycle after src_rd_o.
- snk_data_o  out  8  dump byte.
- snk_vld_o  out  1  one-cycle pulse, snk_data_o valid.
- uart_tx_data_o  out  8  byte to transmit.
- uart_tx_data_vld_o  out  1  transmit request.
- uart_tx_data_rdy_i  in  1  UART transmitter idle.
- uart_rx_data_i  in  8  received byte.
- uart_rx_data_vld_i  in  1  received byte valid (level).
- uart_rx_data_rdy_o  out  1  received byte consumed.

## Operation
- Command bytes: RST=0x2a, RUN=0x2b, CONF_WR=0x2c, CONF_RD=0x2d (not issued), DATA_WR=0x2e, DATA_RD=0x2f.
- Request acceptance: on req_vld_i & req_rdy_o, latch op, addr and size.
- RST and RUN: send the single command byte, then DONE.
- LOAD: send 0x2c, then the 8 config bytes (addr[7:0] … addr[31:24], size[7:0] … size[31:24], LSB first). Then send 0x2e, then size+1 data bytes from the source, then DONE.
- DUMP: send 0x2c and the same 8 config bytes, send 0x2f, then receive size+1 bytes into the sink, then DONE.
- States: IDLE, SEND_CMD, SEND_CFG, SEND_DCMD, FETCH, SEND_DATA, RECV, DONE.
  - IDLE→SEND_CMD on accept.
  - SEND_CMD→DONE for RST/RUN; SEND_CMD→SEND_CFG otherwise.
  - SEND_CFG→SEND_DCMD after byte 7.
  - SEND_DCMD→FETCH (LOAD) or RECV (DUMP).
  - FETCH→SEND_DATA.
  - SEND_DATA→FETCH, or →DONE when cnt==size.
  - RECV→DONE when cnt==size.
  - DONE→IDLE.
- Byte counter cnt: XLEN bits. Cleared on entry to SEND_CFG, SEND_DATA/FETCH and RECV. Compared for equality before increment, so size=0xFFFF_FFFF transfers 2^32 bytes with no wrap error.
- FETCH: assert src_rd_o for one cycle and load src_data_i into the tx register on the next cycle.
- Received bytes outside RECV are handshaked and discarded; snk_vld_o stays 0.
- req_vld_i while busy is ignored.
- Asynchronous reset mid-transfer returns to IDLE immediately. The target must then be resynchronised with an RST request.

## Timing
- Reset values:
  - req_rdy_o=1.
  - done_o, src_rd_o, snk_vld_o, uart_tx_data_vld_o and uart_rx_data_rdy_o = 0.
  - uart_tx_data_o and snk_data_o = 0x00.
- TX handshake:
  - A byte is launched only when uart_tx_data_rdy_i=1. vld rises together with the data.
  - vld is held until rdy is seen low (byte accepted), then vld drops.
  - The next byte waits for the rising edge of rdy. This guarantees at least one idle cycle between bytes, which the responder needs.
- RX handshake:
  - The byte is captured on the rising edge of uart_rx_data_vld_i.
  - uart_rx_data_rdy_o is set the following cycle and held until vld is low.
  - snk_vld_o pulses the cycle after capture.
- Latency from accept to the first vld: 2 cycles. done_o pulses 1 cycle after the last byte completes (TX: rdy rising edge; RX: capture). req_rdy_o rises in the same cycle as done_o.

## Structure
- Shared package ram_rw_pkg holds cmd_en_t (the six command codes) and the op encoding, used by both ram_loader and the target responder.
- Reuse the existing edge2en sub-module for the rising-edge detectors on uart_tx_data_rdy_i and uart_rx_data_vld_i.

## Test plan
- RUN request, UART model with 10-cycle busy: exactly one byte, 0x2b, is sent, then a done_o pulse. req_rdy_o=0 throughout.
- LOAD, addr=0x8000_0010, size=3, source 0xA0..0xA3: the sequence is 0x2c,10,00,00,80,03,00,00,00,0x2e,A0,A1,A2,A3. There are 4 src_rd_o pulses.
- DUMP, addr=0, size=1, UART RX model returns 0x55 then 0xAA: 0x2c + 8 config bytes + 0x2f are sent, then snk_vld_o pulses twice with 0x55 and 0xAA, then done_o.
- Loopback with the target responder and RAM: LOAD 16 bytes, DUMP 16 bytes from the same address. The sink data equals the source data.
- Unsolicited RX byte in IDLE and req_vld_i pulsed mid-LOAD: the RX byte is handshaked with no snk_vld_o, and the second request is ignored.
- Reset asserted during SEND_DATA: all outputs return to their reset values asynchronously. After release, a RST request sends 0x2a.
